// File: rtl/regfile_pkg.sv
// Shared constants and types for the pipelined register file with write-pending scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_rdport.sv
// Single read port: register mux with hardwired-zero r0.
// Optional same-cycle write forwarding when RF_BYPASS_EN is defined.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] mem,
  input  logic [(2**ADDR_W)-1:0]             busy,
  input  logic [ADDR_W-1:0]                  raddr,
`ifdef RF_BYPASS_EN
  input  logic                               we,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [DATA_W-1:0]                  wdata,
  input  logic                               reissue,
`endif
  output logic [DATA_W-1:0]                  rdata,
  output logic                               rbusy
);

  logic isZero;

  always_comb begin
    isZero = (raddr == ADDR_W'(REG_ZERO));
    rdata  = isZero ? '0 : mem[raddr];
    rbusy  = isZero ? 1'b0 : busy[raddr];
`ifdef RF_BYPASS_EN
    // A re-issue in the same cycle keeps the stored busy view: a newer producer is coming.
    if (!isZero && we && (waddr == raddr)) begin
      rdata = wdata;
      if (!reissue) rbusy = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register busy scoreboard and pending-write counter.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_dst,
  input  logic                     flush,
  output logic [CNT_W-1:0]         pend_cnt,
  output logic                     any_busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] memQ;
  logic [DEPTH-1:0]             busyQ, busyD;
  logic [CNT_W-1:0]             cntQ, cntD;
  logic                         wrHit, setHit;

  assign wrHit  = we && (waddr != ADDR_W'(REG_ZERO));
  assign setHit = issue_valid && (issue_dst != ADDR_W'(REG_ZERO));

  // Set wins over clear on the same register; flush drops every claim.
  always_comb begin
    busyD = busyQ;
    if (flush) begin
      busyD = '0;
    end else begin
      if (wrHit)  busyD[waddr]     = 1'b0;
      if (setHit) busyD[issue_dst] = 1'b1;
    end
  end

  // Incremental population count: at most one rise and one fall per cycle outside flush.
  always_comb begin
    cntD = cntQ;
    if (flush) begin
      cntD = '0;
    end else begin
      if (setHit && !busyQ[issue_dst]) cntD = cntD + CNT_W'(1);
      if (wrHit && busyQ[waddr] && !(setHit && (issue_dst == waddr))) cntD = cntD - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memQ  <= '0;
      busyQ <= '0;
      cntQ  <= '0;
    end else begin
      if (wrHit) memQ[waddr] <= wdata;
      busyQ <= busyD;
      cntQ  <= cntD;
    end
  end

  assign pend_cnt = cntQ;
  assign any_busy = (cntQ != '0);

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rdport #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_rdport (
      .mem    (memQ),
      .busy   (busyQ),
      .raddr  (raddr[i*ADDR_W +: ADDR_W]),
`ifdef RF_BYPASS_EN
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .reissue(issue_valid && (issue_dst == raddr[i*ADDR_W +: ADDR_W])),
`endif
      .rdata  (rdata[i*DATA_W +: DATA_W]),
      .rbusy  (rbusy[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default 32x32, two read ports).
// Expectations follow RF_BYPASS_EN when the bundle is built with it.
module tb_regfile_sb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned CNT_W  = ADDR_W + 1;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_dst;
  logic                     flush;
  logic [CNT_W-1:0]         pend_cnt;
  logic                     any_busy;

  int checks = 0;
  int errors = 0;

  regfile_sb #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .issue_valid(issue_valid),
    .issue_dst  (issue_dst),
    .flush      (flush),
    .pend_cnt   (pend_cnt),
    .any_busy   (any_busy)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns+ later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    raddr = {a1, a0};
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0;
    issue_valid = 1'b0; issue_dst = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    raddr = '0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (pend_cnt !== '0 || any_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: pend_cnt=%0d any_busy=%b, want 0/0", pend_cnt, any_busy);
    end
    for (int r = 0; r < 32; r++) begin
      set_rd(ADDR_W'(r), ADDR_W'(r));
      checks++;
      if (rdata !== '0 || rbusy !== '0) begin
        errors++;
        $display("FAIL reset_read r%0d: rdata=%h rbusy=%b, want 0/0", r, rdata, rbusy);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd8; wdata = 32'd216;
    tick();
    we = 1'b0;
    set_rd(5'd5, 5'd8);
    checks++;
    if (rdata[DATA_W +: DATA_W] !== 32'd216) begin
      errors++;
      $display("FAIL wr_rd_port1: got %0d want 216", rdata[DATA_W +: DATA_W]);
    end
    checks++;
    if (rdata[0 +: DATA_W] !== 32'd0) begin
      errors++;
      $display("FAIL wr_rd_port0: got %0d want 0", rdata[0 +: DATA_W]);
    end
  endtask

  task automatic test_r0();
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD;
    issue_valid = 1'b1; issue_dst = 5'd0;
    tick();
    idle_inputs();
    set_rd(5'd0, 5'd0);
    checks++;
    if (rdata !== '0 || rbusy !== '0) begin
      errors++;
      $display("FAIL r0_read: rdata=%h rbusy=%b, want 0/0", rdata, rbusy);
    end
    checks++;
    if (pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL r0_cnt: pend_cnt=%0d want 0", pend_cnt);
    end
  endtask

  task automatic test_busy_lifetime();
    issue_valid = 1'b1; issue_dst = 5'd8;
    tick();
    idle_inputs();
    set_rd(5'd8, 5'd3);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rbusy !== 2'b01 || pend_cnt !== 6'd1 || any_busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_hold c%0d: rbusy=%b cnt=%0d any=%b, want 01/1/1",
                 c, rbusy, pend_cnt, any_busy);
      end
      tick();
    end
    we = 1'b1; waddr = 5'd8; wdata = 32'd7;
    #1;
    checks++;
    if (rbusy[0] !== !BYPASS) begin
      errors++;
      $display("FAIL busy_wb_cycle: rbusy0=%b want %b", rbusy[0], !BYPASS);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rbusy !== 2'b00 || pend_cnt !== 6'd0 || any_busy !== 1'b0 ||
        rdata[0 +: DATA_W] !== 32'd7) begin
      errors++;
      $display("FAIL busy_cleared: rbusy=%b cnt=%0d any=%b data=%0d, want 00/0/0/7",
               rbusy, pend_cnt, any_busy, rdata[0 +: DATA_W]);
    end
  endtask

  task automatic test_set_clear_same();
    issue_valid = 1'b1; issue_dst = 5'd9;
    tick();
    we = 1'b1; waddr = 5'd9; wdata = 32'd5;
    tick();
    idle_inputs();
    set_rd(5'd9, 5'd9);
    checks++;
    if (rbusy !== 2'b11 || pend_cnt !== 6'd1 || rdata[0 +: DATA_W] !== 32'd5) begin
      errors++;
      $display("FAIL set_wins: rbusy=%b cnt=%0d data=%0d, want 11/1/5",
               rbusy, pend_cnt, rdata[0 +: DATA_W]);
    end
    we = 1'b1; waddr = 5'd9; wdata = 32'd6;
    tick();
    checks++;
    if (pend_cnt !== 6'd0 || rbusy !== 2'b00) begin
      errors++;
      $display("FAIL clear_r9: cnt=%0d rbusy=%b, want 0/00", pend_cnt, rbusy);
    end
    wdata = 32'd11;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (pend_cnt !== 6'd0 || rdata[0 +: DATA_W] !== 32'd11) begin
      errors++;
      $display("FAIL clear_idle: cnt=%0d data=%0d, want 0/11", pend_cnt, rdata[0 +: DATA_W]);
    end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      issue_valid = 1'b1; issue_dst = ADDR_W'(r);
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (pend_cnt !== 6'd3) begin
      errors++;
      $display("FAIL pre_flush_cnt: got %0d want 3", pend_cnt);
    end
    flush = 1'b1; issue_valid = 1'b1; issue_dst = 5'd4;
    we = 1'b1; waddr = 5'd5; wdata = 32'h55;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (pend_cnt !== 6'd0 || any_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_cnt: cnt=%0d any=%b, want 0/0", pend_cnt, any_busy);
    end
    for (int r = 1; r <= 4; r += 2) begin
      set_rd(ADDR_W'(r), ADDR_W'(r + 1));
      checks++;
      if (rbusy !== 2'b00) begin
        errors++;
        $display("FAIL flush_busy r%0d/r%0d: rbusy=%b want 00", r, r + 1, rbusy);
      end
    end
    set_rd(5'd5, 5'd0);
    checks++;
    if (rdata[0 +: DATA_W] !== 32'h55) begin
      errors++;
      $display("FAIL flush_write: got %h want 55", rdata[0 +: DATA_W]);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd10; wdata = 32'h1111;
    tick();
    wdata = 32'h1234;
    set_rd(5'd10, 5'd10);
    checks++;
    if (rdata[DATA_W +: DATA_W] !== (BYPASS ? 32'h1234 : 32'h1111)) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h want %h",
               rdata[DATA_W +: DATA_W], BYPASS ? 32'h1234 : 32'h1111);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rdata[0 +: DATA_W] !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_after_edge: got %h want 1234", rdata[0 +: DATA_W]);
    end
  endtask

  task automatic test_mid_reset();
    issue_valid = 1'b1; issue_dst = 5'd6;
    we = 1'b1; waddr = 5'd7; wdata = 32'h77;
    tick();
    rst = 1'b1; issue_dst = 5'd11; waddr = 5'd12; wdata = 32'h99;
    tick();
    rst = 1'b0;
    idle_inputs();
    set_rd(5'd7, 5'd11);
    checks++;
    if (pend_cnt !== 6'd0 || rbusy !== 2'b00 || rdata !== '0) begin
      errors++;
      $display("FAIL mid_reset: cnt=%0d rbusy=%b rdata=%h, want 0/00/0", pend_cnt, rbusy, rdata);
    end
    set_rd(5'd12, 5'd6);
    checks++;
    if (rdata !== '0 || rbusy !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_override: rdata=%h rbusy=%b, want 0/00", rdata, rbusy);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_r0();
    test_busy_lifetime();
    test_set_clear_same();
    test_flush();
    test_bypass();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
